// File: rtl/seq_divider_16_bit_pkg.sv
// Shared constants and state encoding for the 16-bit sequential restoring divider.
package seq_divider_16_bit_pkg;

    localparam int unsigned N_BITS     = 16;
    localparam int unsigned ITER_COUNT = 16;
    localparam int unsigned CNT_WIDTH  = 5;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StDone = 2'b10
    } state_e;

endpackage

// File: rtl/subtract_17_bit.sv
// Trial subtractor: a - b via carry-look-ahead addition of ~b with carry-in 1.
module subtract_17_bit #(
    parameter int unsigned WIDTH = 17
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] diff_o,
    output logic             borrow_o
);

    logic [WIDTH-1:0] b_n;
    logic [WIDTH-1:0] gen;
    logic [WIDTH-1:0] prop;
    logic [WIDTH:0]   carry;

    assign b_n  = ~b_i;
    assign gen  = a_i & b_n;
    assign prop = a_i ^ b_n;

    // Each carry is a flat sum of products over the lower generate/propagate terms.
    always_comb begin
        logic gen_acc;
        logic prop_acc;
        carry    = '0;
        carry[0] = 1'b1;
        gen_acc  = 1'b0;
        prop_acc = 1'b1;
        for (int i = 0; i < int'(WIDTH); i++) begin
            gen_acc  = 1'b0;
            prop_acc = 1'b1;
            for (int j = i; j >= 0; j--) begin
                gen_acc  = gen_acc | (gen[j] & prop_acc);
                prop_acc = prop_acc & prop[j];
            end
            carry[i+1] = gen_acc | (prop_acc & carry[0]);
        end
    end

    assign diff_o   = prop ^ carry[WIDTH-1:0];
    assign borrow_o = ~carry[WIDTH];

endmodule

// File: rtl/seq_divider_16_bit.sv
// Sequential restoring divider: one quotient bit per cycle, 16 RUN cycles per division.
module seq_divider_16_bit #(
    parameter int unsigned N_BITS = seq_divider_16_bit_pkg::N_BITS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [N_BITS-1:0] dividend,
    input  logic [N_BITS-1:0] divisor,
    output logic              busy,
    output logic              done,
    output logic [N_BITS-1:0] quotient,
    output logic [N_BITS-1:0] remainder,
    output logic              div_by_zero
);

    import seq_divider_16_bit_pkg::*;

    localparam logic [CNT_WIDTH-1:0] CntLast = CNT_WIDTH'(ITER_COUNT - 1);

    state_e                state_q, state_d;
    logic [N_BITS-1:0]     rem_q, rem_d;
    logic [N_BITS-1:0]     dq_q, dq_d;
    logic [N_BITS-1:0]     div_q, div_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [N_BITS-1:0]     quot_q, quot_d;
    logic [N_BITS-1:0]     remout_q, remout_d;
    logic                  dbz_q, dbz_d;

    logic                  accept;
    logic                  last_step;
    logic                  borrow;
    logic [N_BITS:0]       shifted;
    logic [N_BITS:0]       trial;
    logic                  unused_trial_msb;

    assign accept    = start & ((state_q == StIdle) | (state_q == StDone));
    assign last_step = (cnt_q == CntLast);
    assign shifted   = {rem_q, dq_q[N_BITS-1]};

    subtract_17_bit #(
        .WIDTH (N_BITS + 1)
    ) u_sub (
        .a_i      (shifted),
        .b_i      ({1'b0, div_q}),
        .diff_o   (trial),
        .borrow_o (borrow)
    );

    // A non-borrowing trial always fits back into N_BITS.
    assign unused_trial_msb = trial[N_BITS];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (start) state_d = (divisor == '0) ? StDone : StRun;
            end
            StRun: begin
                if (last_step) state_d = StDone;
            end
            StDone: begin
                if (start) state_d = (divisor == '0) ? StDone : StRun;
                else       state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy        = (state_q == StRun);
        done        = (state_q == StDone);
        quotient    = quot_q;
        remainder   = remout_q;
        div_by_zero = dbz_q;
    end

    always_comb begin
        rem_d    = rem_q;
        dq_d     = dq_q;
        div_d    = div_q;
        cnt_d    = cnt_q;
        quot_d   = quot_q;
        remout_d = remout_q;
        dbz_d    = dbz_q;
        if (accept) begin
            rem_d = '0;
            dq_d  = dividend;
            div_d = divisor;
            cnt_d = '0;
            // Zero divisor completes immediately with saturated quotient.
            if (divisor == '0) begin
                quot_d   = '1;
                remout_d = dividend;
                dbz_d    = 1'b1;
            end
        end else if (state_q == StRun) begin
            rem_d = borrow ? shifted[N_BITS-1:0] : trial[N_BITS-1:0];
            dq_d  = {dq_q[N_BITS-2:0], ~borrow};
            cnt_d = cnt_q + 1'b1;
            if (last_step) begin
                quot_d   = dq_d;
                remout_d = rem_d;
                dbz_d    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q    <= '0;
            dq_q     <= '0;
            div_q    <= '0;
            cnt_q    <= '0;
            quot_q   <= '0;
            remout_q <= '0;
            dbz_q    <= 1'b0;
        end else begin
            rem_q    <= rem_d;
            dq_q     <= dq_d;
            div_q    <= div_d;
            cnt_q    <= cnt_d;
            quot_q   <= quot_d;
            remout_q <= remout_d;
            dbz_q    <= dbz_d;
        end
    end

endmodule

// File: doc/seq_divider_16_bit.md
SEQ_DIVIDER_16_BIT -- requirements
Module: seq_divider_16_bit

Interface
REQ-001 The block SHALL have parameter N_BITS, default 16, meaning operand/result width; only 16 is supported.
REQ-002 The block SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1, request to begin a division; sampled only in IDLE or DONE.
REQ-005 The block SHALL have port dividend, input, 16, unsigned numerator; captured when start is accepted.
REQ-006 The block SHALL have port divisor, input, 16, unsigned denominator; captured when start is accepted.
REQ-007 The block SHALL have port busy, output, 1, high while a division is in progress.
REQ-008 The block SHALL have port done, output, 1, single-cycle pulse marking valid results.
REQ-009 The block SHALL have port quotient, output, 16, result quotient.
REQ-010 The block SHALL have port remainder, output, 16, result remainder.
REQ-011 The block SHALL have port div_by_zero, output, 1, high with done when the captured divisor was 0.

Function
REQ-012 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-013 In IDLE or DONE, start=1 at edge T SHALL capture the operands, clear the partial remainder and the iteration counter, and enter RUN (busy=1 from T).
REQ-014 Each RUN cycle SHALL perform one restoring step:
  - form trial = {rem[15:0], q_msb} minus {0, divisor} as a 17-bit subtraction;
  - if no borrow, rem = trial and quotient bit = 1;
  - if borrow, restore rem and set quotient bit = 0;
  - shift the quotient/dividend register left by one.
REQ-015 The iteration counter SHALL be 5 bits; after exactly 16 RUN cycles the FSM SHALL enter DONE.
REQ-016 done SHALL be 1 for exactly the one cycle spent in DONE, i.e. 17 cycles after the accepting edge; busy SHALL be 0 in DONE.
REQ-017 quotient and remainder SHALL update only on entry to DONE and hold until the next entry to DONE or reset.
REQ-018 A captured divisor of 0 SHALL skip RUN and enter DONE on the next edge with:
  - quotient=16'hFFFF;
  - remainder=captured dividend;
  - div_by_zero=1.
REQ-019 div_by_zero SHALL be 0 on every nonzero-divisor completion and SHALL hold with the results.
REQ-020 start while in RUN SHALL be ignored; operands SHALL NOT change and latency SHALL NOT change.
REQ-021 start=1 during the DONE cycle SHALL be accepted (back-to-back operation), so done pulses are spaced 17 cycles apart.
REQ-022 Without start, DONE SHALL return to IDLE on the next edge.
REQ-023 Results SHALL satisfy dividend = quotient*divisor + remainder and remainder < divisor for every nonzero divisor.

Reset
REQ-024 rst=1 at any edge SHALL force IDLE and set busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, and clear the counter and internal registers.
REQ-025 rst SHALL take priority over start; a division interrupted by reset SHALL produce no done pulse.

Structure
REQ-026 A shared package SHALL hold the state encoding (IDLE=2'b00, RUN=2'b01, DONE=2'b10), N_BITS and the iteration-count constant 16.
REQ-027 The 17-bit trial subtraction SHALL be one sub-module, subtract_17_bit. It is built from carry-look-ahead addition with inverted subtrahend and carry-in 1, and reports borrow as the inverted carry-out.

Verification
REQ-028 Basic division: dividend=100, divisor=7, start 1 cycle -> done exactly 17 cycles later; quotient=14, remainder=2, div_by_zero=0.
REQ-029 Extremes: 16'hFFFF/1 -> quotient=16'hFFFF, remainder=0; then 3/10 -> quotient=0, remainder=3.
REQ-030 Divide by zero: 5/0 -> done 1 cycle after the accepting edge; quotient=16'hFFFF, remainder=5, div_by_zero=1.
REQ-031 Busy start: 1000/3, then start with 9/9 at cycle 5 -> ignored; results are 333 and 1 at cycle 17.
REQ-032 Back-to-back: start held through DONE with 50000/123 -> second done 17 cycles after the first; quotient=406, remainder=62.
REQ-033 Reset mid-operation: rst pulsed at cycle 8 of a division -> all outputs 0, no done; a fresh 100/7 then completes correctly.
